// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_n(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Receiver-side bundle: serial line in, byte and status strobes out.
interface uart_rx_byte_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (input rx, output data, valid, frame_err, parity_err, busy);
    modport slave  (output rx, input data, valid, frame_err, parity_err, busy);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs with a selectable reset value.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// Oversampled 8N1 UART receiver with mid-bit sampling and one-cycle status strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with an even-parity check.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_byte_if.master bus
);

    localparam int N     = calc_n(CLK_FREQ, BAUD);
    localparam int H     = N / 2;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(H - 1);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    if (N < 4) begin : g_n_check
        $error("uart_rx_byte: N=%0d clocks per bit, need at least 4", N);
    end

    logic rx_s;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.rx),
        .q    (rx_s)
    );

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 rx_d;
    logic                 armed;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q;
    logic                 perr_flag;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data_q    <= '0;
            rx_d      <= 1'b1;
            armed     <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            perr_flag <= 1'b0;
`endif
        end else begin
            rx_d    <= rx_s;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // A held-low line after a frame must go high before the next start counts.
                    if (rx_s) armed <= 1'b1;
                    if (armed && rx_d && !rx_s) begin
                        state  <= START;
                        busy_q <= 1'b1;
                        armed  <= 1'b0;
                    end
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            idx   <= '0;
`ifdef UART_RX_PARITY_EN
                            perr_flag <= 1'b0;
`endif
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_END) begin
                        cnt       <= '0;
                        perr_flag <= rx_s ^ (^shreg);
                        state     <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (cnt == BIT_END) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        armed  <= 1'b0;
                        ferr_q <= !rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_q <= perr_flag;
                        if (rx_s && !perr_flag) begin
`else
                        if (rx_s) begin
`endif
                            data_q  <= shreg;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at N=16, H=8; honours UART_RX_PARITY_EN.
module tb_uart_rx_byte;

    localparam int N = 16;
    localparam int H = 8;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        logic       v;
        logic       fe;
        logic       pe;
        logic [7:0] d;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] last_good;

    uart_rx_byte_if bus();

    uart_rx_byte #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Drives one frame starting at the current falling edge and queues its expected outcome.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_bad);
        exp_t e;
        logic pe;
        pe    = (P == 1) ? par_bad : 1'b0;
        e.v   = stop && !pe;
        e.fe  = !stop;
        e.pe  = pe;
        if (e.v) last_good = b;
        e.d   = last_good;
        // Start edge reaches rx_s two clocks after the pin; strobe lands a clock after the stop sample.
        e.cyc = cyc + 2 + H + 1 + (9 + P) * N;
        sb.push_back(e);
        bus.rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (N) @(negedge clk);
        end
        if (P == 1) begin
            bus.rx = (^b) ^ par_bad;
            repeat (N) @(negedge clk);
        end
        bus.rx = stop;
        repeat (N) @(negedge clk);
    endtask

    task automatic idle(input int clocks);
        bus.rx = 1'b1;
        repeat (clocks) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.valid || bus.frame_err || bus.parity_err)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe valid=%0b frame_err=%0b parity_err=%0b data=%0h at cyc=%0d",
                         bus.valid, bus.frame_err, bus.parity_err, bus.data, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("valid", 32'(bus.valid), 32'(mon_e.v));
                chk("frame_err", 32'(bus.frame_err), 32'(mon_e.fe));
                chk("parity_err", 32'(bus.parity_err), 32'(mon_e.pe));
                chk("data", 32'(bus.data), 32'(mon_e.d));
                chk("strobe_cycle", cyc, mon_e.cyc);
                chk("busy_at_strobe", 32'(bus.busy), 32'd0);
            end
        end
    end

    initial begin
        int c;
        logic [7:0] b;
        logic stop;
        logic pbad;
        int gap;

        last_good = 8'h00;
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_data", 32'(bus.data), 32'h00);
        chk("reset_valid", 32'(bus.valid), 32'd0);
        chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
        chk("reset_parity_err", 32'(bus.parity_err), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        idle(2 * N);

        // Single good frame.
        send_frame(8'h55, 1'b1, 1'b0);
        idle(2 * N);

        // Back-to-back frames with no idle gap.
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(2 * N);

        // Short low glitch must be rejected at the start sample.
        c = cyc;
        bus.rx = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("glitch_busy_t0", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.rx = 1'b1;
        chk("glitch_busy_t0p1", 32'(bus.busy), 32'd1);
        repeat (7) @(negedge clk);
        chk("glitch_busy_t0p8", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("glitch_busy_t0p9", 32'(bus.busy), 32'd0);
        chk("glitch_elapsed", cyc - c, 32'd11);
        idle(2 * N);

        // Break: bad stop bit and line held low for 40 bit times.
        send_frame(8'h00, 1'b0, 1'b0);
        repeat (40 * N) @(negedge clk);
        chk("break_busy", 32'(bus.busy), 32'd0);
        idle(2 * N);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(2 * N);

        // Reset during bit 4 of 0xFF discards the partial byte.
        bus.rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = 1'b1;
            repeat (N) @(negedge clk);
        end
        repeat (N / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_data", 32'(bus.data), 32'h00);
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        last_good = 8'h00;
        rst_n = 1'b1;
        idle(3 * N);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(2 * N);

        if (P == 1) begin
            send_frame(8'h07, 1'b1, 1'b1);
            idle(2 * N);
            send_frame(8'h07, 1'b1, 1'b0);
            idle(2 * N);
        end

        // Random frames, random stop/parity faults and idle gaps.
        for (int k = 0; k < 24; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            pbad = (P == 1) && ($urandom_range(0, 5) == 0);
            send_frame(b, stop, pbad);
            gap  = stop ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20));
            idle(gap);
        end

        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        idle(4 * N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Oversampled 8-bit UART receiver that sits directly upstream of the seven-segment display driver in the serial demo. It synchronises the asynchronous RX pin, detects and validates start bits, samples each data bit at mid-bit, and checks the stop bit. For each correctly framed byte it presents the byte with a one-cycle VALID strobe; a bad stop bit produces a FRAME_ERR strobe instead.

## Interface
- CLK_FREQ, 100000000, CLK frequency in Hz
- BAUD, 9600, line rate in bit/s; N = (CLK_FREQ + BAUD/2) / BAUD clocks per bit (rounded), H = N/2 (floor); N ≥ 4 enforced by elaboration check
- CLK  in  1  system clock; one clock domain only
- RESET_N  in  1  reset, asynchronous and active-low
- RX  in  1  asynchronous serial line, idle high, 8N1 (8E1 with parity, see Configuration)
- DATA  out  8  last good byte, LSB first on the wire; reset 8'h00
- VALID  out  1  one-cycle pulse, DATA newly loaded; reset 0
- FRAME_ERR  out  1  one-cycle pulse, stop bit sampled low; reset 0
- PARITY_ERR  out  1  one-cycle pulse, parity mismatch; reset 0, tied 0 without macro
- BUSY  out  1  high in any state other than IDLE; reset 0

## Operation
- RX passes through a 2-FF synchroniser (reset to 1) giving rx_s; a third register rx_d gives edge detection.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: armed only after rx_s has been seen high; falling edge (rx_d=1, rx_s=0) → START, counter cleared.
- START: after H clocks sample rx_s; 0 → DATA with bit index 0; 1 → IDLE (glitch rejected, no strobe).
- DATA: every N clocks sample rx_s into shift register bit index (LSB first); after index 7 → PARITY or STOP.
- PARITY: after N clocks sample; compare with even parity of the 8 data bits.
- STOP: after N clocks sample rx_s. 1 and no parity error → load DATA, pulse VALID. 0 → pulse FRAME_ERR, DATA held. Parity mismatch → pulse PARITY_ERR, DATA held; both errors may pulse together. Always → IDLE, disarmed until rx_s high.
- Return to IDLE at mid-stop-bit so a following start edge is caught; break condition (RX held low) yields exactly one FRAME_ERR, no retrigger.
- Bit counter width: clog2(N); index counter 3 bits, no wrap beyond 7.
- RESET_N low at any time: state IDLE, all outputs to reset values, partial byte discarded, synchroniser to 1.

## Timing
- t0 = clock edge where rx_s first reads 0; pin-to-rx_s latency 2 clocks.
- Start sample at t0+H; data bit k sampled at t0+H+(k+1)·N, k=0..7.
- Stop sample at t0+H+9N (t0+H+10N with parity); VALID/FRAME_ERR/PARITY_ERR high on the following clock edge for exactly one cycle.
- BUSY rises at t0+1, falls with the strobe cycle.
- Minimum spacing between strobes: 10N−H clocks on back-to-back frames.

## Configuration
- UART_RX_PARITY_EN defined: 8E1 framing, PARITY state present, PARITY_ERR driven.
- Undefined: 8N1 framing, PARITY state absent, PARITY_ERR constant 0, stop sample at t0+H+9N.

## Structure
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), function computing N from CLK_FREQ/BAUD with rounding, constant DATA_BITS = 8.
- Sub-module sync_2ff: parameterised-reset-value two-flop synchroniser, reused for other async inputs.
- All remaining logic in uart_rx_byte; no FIFO (display consumes at most one byte per frame).

## Test plan
Bench uses CLK_FREQ=16, BAUD=1 (N=16, H=8).
- Frame 0x55 with good stop → VALID one cycle at t0+153, DATA=8'h55, FRAME_ERR=0.
- Back-to-back 0xA3 then 0x0F, no idle gap → two VALID pulses 160 clocks apart, DATA 8'hA3 then 8'h0F.
- RX low for 3 clocks then high → no strobe, BUSY returns 0 at t0+9.
- Frame 0x00 with stop bit low, RX held low 40 bits → exactly one FRAME_ERR, DATA unchanged, no VALID until RX high then new start.
- RESET_N asserted at bit 4 of 0xFF, released, then frame 0x3C → no strobe for the aborted byte, VALID with DATA=8'h3C.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 → PARITY_ERR one cycle at t0+169, DATA unchanged; parity bit 1 → VALID, DATA=8'h07.
